// File: rtl/param_data_mem_pkg.sv
// Shared types and constants for the parameterised data memory.
package param_data_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned RD_LAT_1 = 1;
  localparam int unsigned RD_LAT_2 = 2;

endpackage

// File: rtl/mem_array_be.sv
// Byte-enabled synchronous RAM: one read port, one write port, read-first.
module mem_array_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage carries no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Output register only loads on a read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/param_data_mem.sv
// Data memory wrapper: post-reset zero fill, request gating and read latency pipeline.
module param_data_mem
  import param_data_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  ready,
  output logic                  drop
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam state_e      RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  if (((DATA_W % 8) != 0) || (DATA_W == 0)) begin : g_bad_data_w
    $error("param_data_mem: DATA_W must be a non-zero multiple of 8");
  end
  if ((RD_LAT != RD_LAT_1) && (RD_LAT != RD_LAT_2)) begin : g_bad_rd_lat
    $error("param_data_mem: RD_LAT must be 1 or 2");
  end

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;

  logic                w_run;
  logic                w_ram_we;
  logic                w_ram_re;
  logic [NB-1:0]       w_ram_be;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_ram_rdata;

  logic                r_rv1;
  logic                r_ready;
  logic                r_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_STATE;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Fill walks every word once, leaving after the last one.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        if (r_clr_ptr == {ADDR_W{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = RST_STATE;
      end
    endcase
  end

  // RAM port steering: the fill owns the write port while clearing.
  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_ram_we    = 1'b0;
    w_ram_be    = '0;
    w_ram_addr  = addr;
    w_ram_wdata = wdata;
    w_ram_re    = 1'b0;
    if (w_run) begin
      w_ram_we = we;
      w_ram_be = be;
      w_ram_re = en;
    end else begin
      w_ram_we    = 1'b1;
      w_ram_be    = '1;
      w_ram_addr  = r_clr_ptr;
      w_ram_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= (CLEAR_ON_RESET == 0);
      r_drop  <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == ST_RUN);
      r_drop  <= !w_run && (en || we);
      r_rv1   <= w_ram_re;
    end
  end

  mem_array_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_waddr (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_addr),
    .o_rdata (w_ram_rdata)
  );

  if (RD_LAT == RD_LAT_2) begin : g_lat2
    logic              r_rv2;
    logic [DATA_W-1:0] r_rdata2;

    // Second stage captures RAM data only when a read lands in it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rv2    <= 1'b0;
        r_rdata2 <= '0;
      end else begin
        r_rv2 <= r_rv1;
        if (r_rv1) begin
          r_rdata2 <= w_ram_rdata;
        end
      end
    end

    assign rdata  = r_rdata2;
    assign rvalid = r_rv2;
  end else begin : g_lat1
    assign rdata  = w_ram_rdata;
    assign rvalid = r_rv1;
  end

  assign ready = r_ready;
  assign drop  = r_drop;

endmodule

// File: tb/tb_param_data_mem.sv
// Directed bench for param_data_mem: RD_LAT=1/2 with fill, plus a no-fill instance.
module tb_param_data_mem;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata1, rdata2, rdata3;
  logic        rvalid1, rvalid2, rvalid3;
  logic        ready1, ready2, ready3;
  logic        drop1, drop2, drop3;

  int total = 0;
  int bad   = 0;

  param_data_mem #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rvalid(rvalid1), .ready(ready1), .drop(drop1));

  param_data_mem #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .rvalid(rvalid2), .ready(ready2), .drop(drop2));

  param_data_mem #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .rvalid(rvalid3), .ready(ready3), .drop(drop3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rd;
    logic        c3;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  logic [31:0] e1d, e2d;
  logic        e2v;

  function automatic vec_t mk(logic a_en, logic a_we, logic [3:0] a_be, logic [3:0] a_addr,
                              logic [31:0] a_wd, logic a_rv, logic [31:0] a_rd, logic a_c3);
    vec_t t;
    t.en = a_en; t.we = a_we; t.be = a_be; t.addr = a_addr; t.wdata = a_wd;
    t.rv = a_rv; t.rd = a_rd; t.c3 = a_c3;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; we = 1'b0; be = 4'h0; addr = 4'h0; wdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_drop1", drop1, 1'b0);
    chk("rst_ready1", ready1, 1'b0);
    chk("rst_ready2", ready2, 1'b0);
    chk("rst_ready3", ready3, 1'b1);

    // Start a fill, then interrupt it at word 7.
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("pre_ready1_c%0d", c), ready1, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("midclr_ready1", ready1, 1'b0);
    chk("midclr_ready3", ready3, 1'b1);
    tick();
    rst_n = 1'b1;

    // Full fill after release; a write during the fill must be dropped.
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("fill_ready1_c%0d", c), ready1, (c == 16) ? 1'b1 : 1'b0);
      chk($sformatf("fill_ready2_c%0d", c), ready2, (c == 16) ? 1'b1 : 1'b0);
      if (c == 4) begin
        chk("clr_drop1", drop1, 1'b1);
        chk("clr_drop2", drop2, 1'b1);
        we = 1'b0;
      end
      if (c == 5) chk("clr_drop1_once", drop1, 1'b0);
      if (c == 3) begin
        we = 1'b1; be = 4'hF; addr = 4'd9; wdata = 32'hFFFF_FFFF;
      end
    end
    idle();

    for (int a = 0; a < 16; a++) vecs.push_back(mk(1, 0, 4'h0, 4'(a), 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'd3, 32'hAABB_CCDD, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 4'h5, 4'd3, 32'h1122_3344, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 4'h0, 4'd3, 32'h0, 1, 32'hAA22_CC44, 1));
    vecs.push_back(mk(0, 1, 4'h0, 4'd3, 32'hFFFF_FFFF, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 4'h0, 4'd3, 32'h0, 1, 32'hAA22_CC44, 1));
    vecs.push_back(mk(0, 1, 4'hF, 4'd5, 32'h1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 4'd5, 32'h2, 1, 32'h1, 1));
    vecs.push_back(mk(1, 0, 4'h0, 4'd5, 32'h0, 1, 32'h2, 1));
    for (int a = 0; a < 4; a++) vecs.push_back(mk(0, 1, 4'hF, 4'(a), 32'(10 + a), 0, 32'h0, 0));
    for (int a = 0; a < 4; a++) vecs.push_back(mk(1, 0, 4'h0, 4'(a), 32'h0, 1, 32'(10 + a), 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'd15, 32'hDEAD_BEEF, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 4'h0, 4'd15, 32'h0, 1, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0, 0));

    // RD_LAT=2 instance sees each vector's result one cycle after RD_LAT=1.
    e1d = 32'h0; e2d = 32'h0; e2v = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      en = v.en; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
      tick();
      if (v.rv) e1d = v.rd;
      chk($sformatf("v%0d_rvalid1", i), rvalid1, v.rv);
      chk($sformatf("v%0d_rdata1", i), rdata1, e1d);
      chk($sformatf("v%0d_rvalid2", i), rvalid2, e2v);
      chk($sformatf("v%0d_rdata2", i), rdata2, e2d);
      chk($sformatf("v%0d_rvalid3", i), rvalid3, v.rv);
      if (v.c3 && v.rv) chk($sformatf("v%0d_rdata3", i), rdata3, v.rd);
      e2v = v.rv;
      if (v.rv) e2d = v.rd;
    end
    idle();

    // Reset while a RD_LAT=2 read is in flight.
    en = 1'b1; addr = 4'd0;
    tick();
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("inflight_rvalid2", rvalid2, 1'b0);
    chk("inflight_rdata2", rdata2, 32'h0);
    chk("inflight_rdata1", rdata1, 32'h0);
    chk("inflight_ready1", ready1, 1'b0);
    chk("inflight_ready3", ready3, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_rst_rvalid2_c%0d", c), rvalid2, 1'b0);
    end

    // No-fill instance keeps its contents across reset; filling instance drops.
    en = 1'b1; addr = 4'd5;
    tick();
    chk("keep_rvalid3", rvalid3, 1'b1);
    chk("keep_rdata3", rdata3, 32'h2);
    chk("keep_drop1", drop1, 1'b1);
    chk("keep_rvalid1", rvalid1, 1'b0);
    idle();
    tick();
    chk("keep_drop1_end", drop1, 1'b0);
    chk("keep_rvalid3_end", rvalid3, 1'b0);
    chk("keep_rdata3_hold", rdata3, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
